mp_ram_rr: RTL

- Parametrised single-clock successor to the dual-port RAM: one storage array shared by NUM_PORTS requestors.
- A round-robin arbiter grants one access per cycle.
- Writes support per-byte enables; reads have a configurable pipeline latency.
- After reset, the block runs a hardware zero-fill sequence before accepting any request.

---
 rtl/mp_ram_rr.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mp_ram_rr.sv
// Shared single-clock RAM serving NUM_PORTS requestors through a round-robin arbiter.
// Byte-enabled writes, 1- or 2-cycle read latency, hardware zero-fill after reset.
module mp_ram_rr #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_PORTS  = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS-1:0]             we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be,
  output logic [NUM_PORTS-1:0]             gnt,
  output logic [NUM_PORTS-1:0]             rvalid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  rdata,
  output logic                             init_done
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int BYTES = DATA_WIDTH/8;
  localparam int PTR_W = $clog2(NUM_PORTS);

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic                            state_r;
  logic [ADDR_WIDTH-1:0]           init_cnt_r;
  logic [PTR_W-1:0]                ptr_r;
  logic [DATA_WIDTH-1:0]           mem_r [DEPTH];

  logic [NUM_PORTS-1:0]            gnt_s;
  logic [PTR_W-1:0]                gnt_idx_s;
  logic                            found_s;
  logic                            grant_s;
  logic                            sel_we_s;
  logic [ADDR_WIDTH-1:0]           sel_addr_s;
  logic [DATA_WIDTH-1:0]           sel_wdata_s;
  logic [BYTES-1:0]                sel_be_s;
  logic [DATA_WIDTH-1:0]           mem_rd_s;
  logic [NUM_PORTS-1:0]            rd_onehot_s;
  logic [NUM_PORTS-1:0]            st_valid_s;
  logic [DATA_WIDTH-1:0]           st_data_s;
  logic [NUM_PORTS-1:0]            rvalid_r;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_r;

  // Round-robin search from the pointer upward; nothing is granted until zero-fill ends.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_s     = '0;
    gnt_idx_s = '0;
    found_s   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(ptr_r) + i) % NUM_PORTS;
      if (!found_s && req[idx] && (state_r == ST_RUN)) begin
        gnt_s[idx] = 1'b1;
        gnt_idx_s  = PTR_W'(idx);
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign gnt         = gnt_s;
  assign grant_s     = found_s;
  assign sel_we_s    = we[gnt_idx_s];
  assign sel_addr_s  = addr[gnt_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata_s = wdata[gnt_idx_s*DATA_WIDTH +: DATA_WIDTH];
  assign sel_be_s    = be[gnt_idx_s*BYTES +: BYTES];
  assign mem_rd_s    = mem_r[sel_addr_s];
  assign rd_onehot_s = (grant_s && !sel_we_s) ? gnt_s : '0;

  // Control state: zero-fill counter, INIT->RUN transition and arbiter pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_INIT;
      init_cnt_r <= '0;
      ptr_r      <= '0;
    end else begin
      if (state_r == ST_INIT) begin
        init_cnt_r <= init_cnt_r + ADDR_WIDTH'(1);
        if (init_cnt_r == ADDR_WIDTH'(DEPTH-1)) begin
          state_r <= ST_RUN;
        end
      end
      if (grant_s) begin
        ptr_r <= (gnt_idx_s == PTR_W'(NUM_PORTS-1)) ? '0 : gnt_idx_s + PTR_W'(1);
      end
    end
  end

  // Storage array: zero-fill during INIT, byte-masked writes in RUN.
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      mem_r[init_cnt_r] <= '0;
    end else if (grant_s && sel_we_s) begin
      for (int b = 0; b < BYTES; b++) begin
        if (sel_be_s[b]) begin
          mem_r[sel_addr_s][b*8 +: 8] <= sel_wdata_s[b*8 +: 8];
        end
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [NUM_PORTS-1:0]  p_valid_r;
      logic [DATA_WIDTH-1:0] p_data_r;

      // Extra read stage; flushed by reset so no stale read surfaces afterwards.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          p_valid_r <= '0;
          p_data_r  <= '0;
        end else begin
          p_valid_r <= rd_onehot_s;
          p_data_r  <= mem_rd_s;
        end
      end

      assign st_valid_s = p_valid_r;
      assign st_data_s  = p_data_r;
    end else begin : g_lat1
      assign st_valid_s = rd_onehot_s;
      assign st_data_s  = mem_rd_s;
    end
  endgenerate

  // Output stage: one-cycle rvalid pulse, rdata held per port until its next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_r <= '0;
      rdata_r  <= '0;
    end else begin
      rvalid_r <= st_valid_s;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (st_valid_s[p]) begin
          rdata_r[p*DATA_WIDTH +: DATA_WIDTH] <= st_data_s;
        end
      end
    end
  end

  assign rvalid    = rvalid_r;
  assign rdata     = rdata_r;
  assign init_done = (state_r == ST_RUN);

endmodule
